// File: rtl/display_pkg.sv
// display_pkg: shared FSM states, segment patterns and the digit encoder
package display_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: shift-add-3 converter, one input bit per cycle, 10 cycles per value
module bin2bcd_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [9:0]  bin_i,
  output logic        done_o,
  output logic [15:0] bcd_o
);
  logic [25:0] sr_q, sr_d, adj;
  logic [3:0]  cnt_q;
  logic        busy_q;
  // done marks the cycle whose edge performs the tenth and final shift
  assign done_o = busy_q && cnt_q == 4'd9;
  assign bcd_o  = sr_q[25:10];
  // add 3 to every BCD nibble that is 5 or more, then shift the whole register left
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 4; i++)
      adj[10+4*i +: 4] = sr_q[10+4*i +: 4] >= 4'd5 ? sr_q[10+4*i +: 4] + 4'd3 : sr_q[10+4*i +: 4];
    sr_d = {adj[24:0], 1'b0};
  end
  // load on start, otherwise shift while busy; result stays put once idle
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      sr_q   <= {16'd0, bin_i};
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_q + 4'd1;
      busy_q <= !done_o;
    end
  end
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: accepts a binary value, converts it to BCD and scans three 7-segment digits
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] num,
  input  logic       num_valid,
  output logic       num_ready,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       ovf,
  output logic       upd
);
  localparam int PW = $clog2(SCAN_DIV);
  state_t        state_q, state_d;
  logic          start, done, blank;
  logic [15:0]   bcd;
  logic [3:0]    u_q, t_q, h_q, dig;
  logic          ovf_q, upd_q;
  logic [PW-1:0] pre_q;
  logic [1:0]    idx_q;
  logic [6:0]    seg_q;
  logic [2:0]    an_q;
  bin2bcd_serial u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (num),
    .done_o  (done),
    .bcd_o   (bcd)
  );
  assign num_ready = state_q == IDLE;
  assign ovf       = ovf_q;
  assign upd       = upd_q;
  assign seg       = seg_q;
  assign an        = an_q;
  // accept in IDLE, wait for the converter's final shift, then commit for one cycle
  always_comb begin
    start   = state_q == IDLE && num_valid;
    state_d = state_q == IDLE    ? (num_valid ? CONVERT : IDLE) :
              state_q == CONVERT ? (done ? COMMIT : CONVERT) : IDLE;
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // digit registers only change on COMMIT, so the display never shows a partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      u_q   <= '0;
      t_q   <= '0;
      h_q   <= '0;
      ovf_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      upd_q <= state_q == COMMIT;
      if (state_q == COMMIT) begin
        u_q   <= bcd[3:0];
        t_q   <= bcd[7:4];
        h_q   <= bcd[11:8];
        ovf_q <= bcd[15:12] != 4'd0;
      end
    end
  end
  // free-running prescaler steps the scan index units -> tens -> hundreds
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_q <= '0;
      idx_q <= idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end
  // leading-zero blanking applies only to hundreds and tens
  always_comb begin
    dig   = idx_q == 2'd2 ? h_q : idx_q == 2'd1 ? t_q : u_q;
    blank = BLANK_LZ && ((idx_q == 2'd2 && h_q == 4'd0) || (idx_q == 2'd1 && h_q == 4'd0 && t_q == 4'd0));
  end
  // seg and an registered together from the same index so they always switch on one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 3'b001;
      seg_q <= SEG_0;
    end else begin
      an_q  <= 3'b001 << idx_q;
      seg_q <= blank ? SEG_BLANK : seg7_encode(dig);
    end
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed and random stimulus against an arithmetic model of the display
module tb_display_scan_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] num = '0;
  logic       num_valid = 1'b0;
  logic       num_ready, ovf, upd, ready_b, ovf_b, upd_b;
  logic [6:0] seg, seg_b;
  logic [2:0] an, an_b;
  int errs = 0;
  int checks = 0;
  int k = 0;
  int n0 = 0;
  int pend = 0;
  int m_val = 0;
  int p_val = 0;
  int p_idx = 0;
  bit m_busy = 0;
  bit e_upd = 0;
  logic [2:0] e_an = 3'b001;
  logic [6:0] e_seg = 7'b0111111;
  logic [6:0] e_seg_b = 7'b0111111;
  logic [6:0] segtab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  display_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst(rst), .num(num), .num_valid(num_valid), .num_ready(num_ready),
    .seg(seg), .an(an), .ovf(ovf), .upd(upd)
  );
  display_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .num(num), .num_valid(num_valid), .num_ready(ready_b),
    .seg(seg_b), .an(an_b), .ovf(ovf_b), .upd(upd_b)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int v, input int idx, input bit bl);
    int h, t, u, d;
    h = (v / 100) % 10;
    t = (v / 10) % 10;
    u = v % 10;
    d = idx == 2 ? h : idx == 1 ? t : u;
    if (bl && ((idx == 2 && h == 0) || (idx == 1 && h == 0 && t == 0))) return 7'b0000000;
    return segtab[d];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s at edge %0d: got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [9:0] x);
    bit acc;
    rst = r;
    num_valid = v;
    num = x;
    acc = !r && v && !m_busy;
    @(posedge clk);
    if (r) begin
      k = 0; m_busy = 0; m_val = 0; p_val = 0; p_idx = 0; e_upd = 0;
      e_an = 3'b001; e_seg = 7'b0111111; e_seg_b = 7'b0111111;
    end else begin
      e_an = 3'b001 << p_idx;
      e_seg = exp_seg(p_val, p_idx, 1'b0);
      e_seg_b = exp_seg(p_val, p_idx, 1'b1);
      k++;
      e_upd = 0;
      if (acc) begin
        n0 = k; pend = int'(x); m_busy = 1;
      end else if (m_busy && k == n0 + 11) begin
        m_val = pend; m_busy = 0; e_upd = 1;
      end
      p_idx = (k / 4) % 3;
      p_val = m_val % 1000;
    end
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("an_b", 32'(an_b), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("seg_b", 32'(seg_b), 32'(e_seg_b));
    chk("ready", 32'(num_ready), 32'(!m_busy));
    chk("upd", 32'(upd), 32'(e_upd));
    chk("ovf", 32'(ovf), 32'(m_val > 999));
    chk("ovf_b", 32'(ovf_b), 32'(m_val > 999));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 10'($urandom));
  endtask

  task automatic send(input logic [9:0] x);
    step(1'b0, 1'b1, x);
  endtask

  initial begin
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(12);
    send(10'd375);  idle(14);
    send(10'd1023); idle(14);
    send(10'd999);  idle(14);
    send(10'd7);    idle(14);
    send(10'd40);   idle(14);
    send(10'd5);    idle(2);
    send(10'd888);  idle(14);
    send(10'($urandom_range(1, 1023))); idle(4);
    step(1'b1, 1'b0, '0);
    idle(6);
    while (((k + 12) % 4) != 0) idle(1);
    send(10'd642);  idle(14);
    repeat (300) step(1'b0, 1'($urandom_range(0, 3) == 0), 10'($urandom));
    if ($urandom_range(0, 1) == 1) step(1'b1, 1'b0, '0);
    idle(20);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
